handshake_const_check: RTL and testbench

HANDSHAKE_CONST_CHECK -- requirements
Module: handshake_const_check

---
 rtl/handshake_const_check.sv | 107 ++++++++++
 tb/tb_handshake_const_check.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_const_check.sv
// Accepts data tokens, forwards a control token for each one equal to CONST_VALUE,
// and keeps match/mismatch statistics with a sticky error and first-bad capture.
module handshake_const_check #(
   parameter int unsigned            DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0]  CONST_VALUE = '0,
   parameter int unsigned            CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   input  logic                  clr,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] first_bad,
   output logic [CNT_WIDTH-1:0]  match_cnt,
   output logic [CNT_WIDTH-1:0]  mismatch_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    match_cnt_q, match_cnt_d;
   logic [CNT_WIDTH-1:0]    mismatch_cnt_q, mismatch_cnt_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   first_bad_q, first_bad_d;
   logic                    accept;
   logic                    hit;
   logic                    miss;
   logic                    drain;

   // Handshake decode; ready stays high in reset so offered tokens are swallowed
   always_comb begin
      ins_ready = rst || (state_q == EMPTY) || outs_ready;
      accept    = ins_valid && ins_ready;
      hit       = accept && (ins == CONST_VALUE);
      miss      = accept && (ins != CONST_VALUE);
      drain     = (state_q == FULL) && outs_ready;
   end

   // Token FSM: next state and held control token
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (hit) state_d = FULL;
         FULL:  if (drain && !hit) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Statistics; clr wins over a same-cycle accept
   always_comb begin
      match_cnt_d    = match_cnt_q;
      mismatch_cnt_d = mismatch_cnt_q;
      err_d          = err_q;
      first_bad_d    = first_bad_q;
      if (clr) begin
         match_cnt_d    = '0;
         mismatch_cnt_d = '0;
         err_d          = 1'b0;
         first_bad_d    = '0;
      end else begin
         if (hit && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + CNT_WIDTH'(1);
         end
         if (miss) begin
            if (mismatch_cnt_q != CNT_MAX) begin
               mismatch_cnt_d = mismatch_cnt_q + CNT_WIDTH'(1);
            end
            err_d = 1'b1;
            if (!err_q) first_bad_d = ins;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= EMPTY;
         match_cnt_q    <= '0;
         mismatch_cnt_q <= '0;
         err_q          <= 1'b0;
         first_bad_q    <= '0;
      end else begin
         state_q        <= state_d;
         match_cnt_q    <= match_cnt_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         err_q          <= err_d;
         first_bad_q    <= first_bad_d;
      end
   end

   always_comb begin
      outs_valid   = (state_q == FULL);
      err          = err_q;
      first_bad    = first_bad_q;
      match_cnt    = match_cnt_q;
      mismatch_cnt = mismatch_cnt_q;
   end

endmodule

// File: tb/tb_handshake_const_check.sv
// Scoreboarded bench: matching accepts queue expected control tokens, a monitor pops on drains;
// directed steps check statistics against hand-computed values.
module tb_handshake_const_check;

   localparam int unsigned   DW = 27;
   localparam int unsigned   CW = 4;
   localparam logic [DW-1:0] K  = 27'h7BDCCDC;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] ins;
   logic          ins_valid;
   logic          ins_ready;
   logic          outs_valid;
   logic          outs_ready;
   logic          clr;
   logic          err;
   logic [DW-1:0] first_bad;
   logic [CW-1:0] match_cnt;
   logic [CW-1:0] mismatch_cnt;

   int tests  = 0;
   int fails  = 0;
   int cyc    = 0;
   int drains = 0;
   int exp_q[$];
   logic m_full = 1'b0;

   handshake_const_check #(
      .DATA_WIDTH (DW),
      .CONST_VALUE(K),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ins         (ins),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .outs_valid  (outs_valid),
      .outs_ready  (outs_ready),
      .clr         (clr),
      .err         (err),
      .first_bad   (first_bad),
      .match_cnt   (match_cnt),
      .mismatch_cnt(mismatch_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference handshake model: checks ready/valid each cycle, queues expected control tokens
   always @(negedge clk) begin
      logic m_ready;
      logic m_hit;
      m_ready = rst || !m_full || outs_ready;
      chk("ins_ready", 32'(ins_ready), 32'(m_ready));
      chk("outs_valid", 32'(outs_valid), 32'(m_full));
      if (rst) begin
         m_full = 1'b0;
         exp_q.delete();
      end else begin
         m_hit = ins_valid && m_ready && (ins == K);
         if (m_hit) exp_q.push_back(cyc + 1);
         if (m_hit) m_full = 1'b1;
         else if (m_full && outs_ready) m_full = 1'b0;
      end
   end

   // Drain monitor: every control token taken must match a queued expectation
   always @(negedge clk) begin
      if (!rst && outs_valid && outs_ready) begin
         drains++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL drain_unexpected: got drain expected none (cycle %0d)", cyc);
         end else begin
            int e;
            e = exp_q.pop_front();
            chk("drain_latency", 32'(cyc >= e), 32'd1);
         end
      end
   end

   task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic c, input logic r);
      ins_valid  = v;
      ins        = d;
      outs_ready = ordy;
      clr        = c;
      rst        = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stats(input string nm, input logic [CW-1:0] m, input logic [CW-1:0] mm,
                            input logic e, input logic [DW-1:0] fb);
      chk({nm, "_match_cnt"}, 32'(match_cnt), 32'(m));
      chk({nm, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'(mm));
      chk({nm, "_err"}, 32'(err), 32'(e));
      chk({nm, "_first_bad"}, 32'(first_bad), 32'(fb));
   endtask

   initial begin
      int d0;
      ins_valid = 1'b0; ins = '0; outs_ready = 1'b1; clr = 1'b0; rst = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      step(1'b1, K, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk_stats("reset", 4'd0, 4'd0, 1'b0, 27'd0);
      chk("reset_outs_valid", 32'(outs_valid), 32'd0);

      // Single match
      step(1'b1, K, 1'b1, 1'b0, 1'b0);
      chk("single_outs_valid", 32'(outs_valid), 32'd1);
      chk_stats("single", 4'd1, 4'd0, 1'b0, 27'd0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("single_drained", 32'(outs_valid), 32'd0);

      // Two mismatches
      step(1'b1, 27'h0000001, 1'b1, 1'b0, 1'b0);
      step(1'b1, 27'h0000002, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("mismatch_outs_valid", 32'(outs_valid), 32'd0);
      chk_stats("mismatch", 4'd1, 4'd2, 1'b1, 27'h0000001);

      // Backpressure
      step(1'b1, K, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, K, 1'b0, 1'b0, 1'b0);
         chk("bp_ins_ready", 32'(ins_ready), 32'd0);
         chk("bp_outs_valid", 32'(outs_valid), 32'd1);
         chk("bp_match_cnt", 32'(match_cnt), 32'd2);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, K, 1'b1, 1'b0, 1'b0);
         chk("bp_resume_match_cnt", 32'(match_cnt), 32'(3 + i));
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("bp_end_outs_valid", 32'(outs_valid), 32'd0);
      chk("bp_end_match_cnt", 32'(match_cnt), 32'd5);

      // clr collides with a matching accept
      step(1'b1, K, 1'b1, 1'b1, 1'b0);
      chk("clr_outs_valid", 32'(outs_valid), 32'd1);
      chk_stats("clr", 4'd0, 4'd0, 1'b0, 27'd0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Saturation with 20 back-to-back matches
      d0 = drains;
      for (int i = 0; i < 20; i++) step(1'b1, K, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("sat_match_cnt", 32'(match_cnt), 32'hF);
      chk("sat_drains", 32'(drains - d0), 32'd20);

      // Reset mid-operation with a pending token
      step(1'b1, 27'h0000003, 1'b1, 1'b0, 1'b0);
      step(1'b1, K, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_outs_valid", 32'(outs_valid), 32'd1);
      chk_stats("pre_rst", 4'hF, 4'd1, 1'b1, 27'h0000003);
      d0 = drains;
      step(1'b1, K, 1'b0, 1'b1, 1'b1);
      chk("rst_outs_valid", 32'(outs_valid), 32'd0);
      chk_stats("rst", 4'd0, 4'd0, 1'b0, 27'd0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("rst_no_drain", 32'(drains - d0), 32'd0);
      chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("total_drains", 32'(drains), 32'd26);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
